aer_spike_encoder: RTL and testbench

AER_SPIKE_ENCODER -- requirements
Module: aer_spike_encoder

---
 rtl/aer_spike_encoder.sv | 149 ++++++++++++++
 tb/tb_aer_spike_encoder.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aer_spike_encoder.sv
// Converts a parallel spike vector into address-event (addr, timestep) records queued in a show-ahead FIFO.
// First event is valid two cycles after an accepted strobe; strobes arriving while bits are still pending are dropped.

module aer_spike_fifo #(
   parameter int DEPTH = 16,
   parameter int W     = 11
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic [W-1:0]               push_dat,
   input  logic                       pop,
   output logic [W-1:0]               head_dat,
   output logic                       not_empty,
   output logic                       full,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] cnt_nxt;
   logic          do_push;
   logic          do_pop;

   assign do_push   = push && !full;
   assign do_pop    = pop && not_empty;
   assign not_empty = (count != '0);
   assign head_dat  = mem[rd_ptr];

   always_comb begin
      cnt_nxt = count;
      case ({do_push, do_pop})
         2'b10:   cnt_nxt = count + CW'(1);
         2'b01:   cnt_nxt = count - CW'(1);
         default: cnt_nxt = count;
      endcase
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= cnt_nxt;
         full  <= (cnt_nxt == CW'(DEPTH));
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && do_push) mem[wr_ptr] <= push_dat;
   end
endmodule

module aer_spike_encoder #(
   parameter int FIFO_DEPTH = 16,
   parameter int TS_WIDTH   = 8
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [7:0]                    spike_in,
   input  logic                          spike_strobe,
   output logic                          spike_ready,
   output logic [2:0]                    aer_addr,
   output logic [TS_WIDTH-1:0]           aer_ts,
   output logic                          aer_valid,
   input  logic                          aer_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overflow,
   output logic [7:0]                    drop_cnt
);
   localparam int EW = 3 + TS_WIDTH;

   logic [7:0]          mask;
   logic [7:0]          mask_nxt;
   logic [TS_WIDTH-1:0] ts_cnt;
   logic [TS_WIDTH-1:0] ts_latch;
   logic [2:0]          scan_idx;
   logic                scan_push;
   logic                fifo_full;
   logic                fifo_vld;
   logic [EW-1:0]       head;

   always_comb begin
      scan_idx = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (mask[i]) scan_idx = 3'(i);
      end
   end

   // Stall on the registered full flag even if a pop frees a slot this cycle.
   assign scan_push = (mask != 8'd0) && !fifo_full;

   always_comb begin
      mask_nxt = mask;
      if (scan_push) mask_nxt[scan_idx] = 1'b0;
      if (spike_strobe && spike_ready) mask_nxt = spike_in;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mask        <= 8'd0;
         ts_cnt      <= '0;
         ts_latch    <= '0;
         spike_ready <= 1'b1;
         overflow    <= 1'b0;
         drop_cnt    <= 8'd0;
      end else begin
         mask        <= mask_nxt;
         spike_ready <= (mask_nxt == 8'd0);
         if (spike_strobe) begin
            ts_cnt <= ts_cnt + TS_WIDTH'(1);
            if (spike_ready) begin
               ts_latch <= ts_cnt;
            end else begin
               overflow <= 1'b1;
               if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
            end
         end
      end
   end

   aer_spike_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (EW)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (scan_push),
      .push_dat  ({scan_idx, ts_latch}),
      .pop       (aer_ready),
      .head_dat  (head),
      .not_empty (fifo_vld),
      .full      (fifo_full),
      .count     (fifo_count)
   );

   // Outputs read as zero when empty so the post-reset state is clean without resetting storage.
   assign aer_valid = fifo_vld;
   assign aer_addr  = fifo_vld ? head[EW-1:TS_WIDTH] : 3'd0;
   assign aer_ts    = fifo_vld ? head[TS_WIDTH-1:0] : '0;
endmodule

// File: tb/tb_aer_spike_encoder.sv
// Randomized and directed bench for aer_spike_encoder against a queue-based reference model.
module tb_aer_spike_encoder;
   localparam int DEPTH = 16;
   localparam int TSW   = 8;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [7:0]    spike_in = 8'd0;
   logic          spike_strobe = 1'b0;
   logic          spike_ready;
   logic [2:0]    aer_addr;
   logic [TSW-1:0] aer_ts;
   logic          aer_valid;
   logic          aer_ready = 1'b0;
   logic [4:0]    fifo_count;
   logic          overflow;
   logic [7:0]    drop_cnt;

   aer_spike_encoder #(.FIFO_DEPTH(DEPTH), .TS_WIDTH(TSW)) dut (
      .clk          (clk),
      .reset        (reset),
      .spike_in     (spike_in),
      .spike_strobe (spike_strobe),
      .spike_ready  (spike_ready),
      .aer_addr     (aer_addr),
      .aer_ts       (aer_ts),
      .aer_valid    (aer_valid),
      .aer_ready    (aer_ready),
      .fifo_count   (fifo_count),
      .overflow     (overflow),
      .drop_cnt     (drop_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      int addr;
      int ts;
   } ev_t;

   ev_t m_pend[$];
   ev_t m_fifo[$];
   ev_t obs[$];
   int  m_ts;
   int  m_ovf;
   int  m_drop;
   int  n_cmp = 0;
   int  n_err = 0;

   task automatic chk(input string tag, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference: pending events ordered by address, a bounded FIFO queue, and counters.
   task automatic model_step(input logic rst, input logic stb, input logic [7:0] si, input logic rdy);
      bit accept;
      bit full;
      ev_t e;
      if (rst) begin
         m_pend.delete();
         m_fifo.delete();
         m_ts = 0;
         m_ovf = 0;
         m_drop = 0;
         return;
      end
      accept = (m_pend.size() == 0);
      full   = (m_fifo.size() == DEPTH);
      if (rdy && m_fifo.size() > 0) void'(m_fifo.pop_front());
      if (m_pend.size() > 0 && !full) begin
         e = m_pend.pop_front();
         m_fifo.push_back(e);
      end
      if (stb) begin
         if (accept) begin
            for (int i = 0; i < 8; i++) begin
               if (si[i]) begin
                  e.addr = i;
                  e.ts   = m_ts;
                  m_pend.push_back(e);
               end
            end
         end else begin
            m_ovf = 1;
            if (m_drop < 255) m_drop++;
         end
         m_ts = (m_ts + 1) % (1 << TSW);
      end
   endtask

   task automatic check_model();
      chk("m_ready", int'(spike_ready), (m_pend.size() == 0) ? 1 : 0);
      chk("m_valid", int'(aer_valid), (m_fifo.size() != 0) ? 1 : 0);
      chk("m_count", int'(fifo_count), m_fifo.size());
      chk("m_addr", int'(aer_addr), (m_fifo.size() != 0) ? m_fifo[0].addr : 0);
      chk("m_ts", int'(aer_ts), (m_fifo.size() != 0) ? m_fifo[0].ts : 0);
      chk("m_ovf", int'(overflow), m_ovf);
      chk("m_drop", int'(drop_cnt), m_drop);
   endtask

   task automatic cyc(input logic rst, input logic stb, input logic [7:0] si, input logic rdy);
      ev_t e;
      reset = rst;
      spike_strobe = stb;
      spike_in = si;
      aer_ready = rdy;
      if (!rst && aer_valid && rdy) begin
         e.addr = int'(aer_addr);
         e.ts   = int'(aer_ts);
         obs.push_back(e);
      end
      @(posedge clk);
      #1;
      model_step(rst, stb, si, rdy);
      check_model();
   endtask

   task automatic idle(input logic rdy);
      cyc(1'b0, 1'b0, 8'd0, rdy);
   endtask

   task automatic wait_ready(input logic rdy);
      int n = 0;
      while (!spike_ready && n < 50) begin
         idle(rdy);
         n++;
      end
      if (!spike_ready) chk("wait_ready_timeout", 0, 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int a5_addr[4];
      int n;
      a5_addr[0] = 0; a5_addr[1] = 2; a5_addr[2] = 5; a5_addr[3] = 7;
      #1;

      // Reset state
      cyc(1'b1, 1'b0, 8'd0, 1'b0);
      cyc(1'b1, 1'b0, 8'd0, 1'b0);
      chk("rst_valid", int'(aer_valid), 0);
      chk("rst_count", int'(fifo_count), 0);
      chk("rst_ready", int'(spike_ready), 1);
      chk("rst_addr", int'(aer_addr), 0);
      chk("rst_ts", int'(aer_ts), 0);
      chk("rst_ovf", int'(overflow), 0);
      chk("rst_drop", int'(drop_cnt), 0);

      // Basic order and latency
      cyc(1'b0, 1'b1, 8'hA5, 1'b1);
      chk("a5_valid_n1", int'(aer_valid), 0);
      for (int k = 0; k < 4; k++) begin
         idle(1'b1);
         chk("a5_valid", int'(aer_valid), 1);
         chk("a5_addr", int'(aer_addr), a5_addr[k]);
         chk("a5_ts", int'(aer_ts), 0);
      end
      idle(1'b1);
      chk("a5_valid_n6", int'(aer_valid), 0);

      // Back-pressure, overflow, drain
      cyc(1'b1, 1'b0, 8'd0, 1'b0);
      cyc(1'b0, 1'b1, 8'hFF, 1'b0);
      wait_ready(1'b0);
      cyc(1'b0, 1'b1, 8'hFF, 1'b0);
      n = 0;
      while (fifo_count != 5'd16 && n < 40) begin
         idle(1'b0);
         n++;
      end
      chk("bp_count", int'(fifo_count), 16);
      chk("bp_ready", int'(spike_ready), 1);
      cyc(1'b0, 1'b1, 8'hFF, 1'b0);
      chk("bp_pending", int'(spike_ready), 0);
      chk("bp_count3", int'(fifo_count), 16);
      cyc(1'b0, 1'b1, 8'hFF, 1'b0);
      chk("bp_ovf", int'(overflow), 1);
      chk("bp_drop", int'(drop_cnt), 1);
      for (int k = 0; k < 5; k++) begin
         idle(1'b0);
         chk("bp_hold_addr", int'(aer_addr), 0);
         chk("bp_hold_ts", int'(aer_ts), 0);
      end
      obs.delete();
      for (int k = 0; k < 40; k++) idle(1'b1);
      chk("drain_events", obs.size(), 24);
      for (int i = 0; i < obs.size() && i < 24; i++) begin
         chk("drain_addr", obs[i].addr, i % 8);
         chk("drain_ts", obs[i].ts, i / 8);
      end
      chk("drain_count", int'(fifo_count), 0);

      // Timestamp wrap
      cyc(1'b1, 1'b0, 8'd0, 1'b1);
      obs.delete();
      for (int k = 0; k < 257; k++) begin
         wait_ready(1'b1);
         cyc(1'b0, 1'b1, 8'h01, 1'b1);
      end
      for (int k = 0; k < 6; k++) idle(1'b1);
      chk("wrap_events", obs.size(), 257);
      if (obs.size() >= 2) begin
         chk("wrap_prev_ts", obs[obs.size()-2].ts, 255);
         chk("wrap_last_ts", obs[obs.size()-1].ts, 0);
         chk("wrap_last_addr", obs[obs.size()-1].addr, 0);
      end

      // Reset mid-run
      cyc(1'b1, 1'b0, 8'd0, 1'b0);
      cyc(1'b0, 1'b1, 8'h1F, 1'b0);
      wait_ready(1'b0);
      cyc(1'b0, 1'b1, 8'hF0, 1'b0);
      chk("mid_count", int'(fifo_count), 5);
      chk("mid_ready", int'(spike_ready), 0);
      cyc(1'b1, 1'b0, 8'd0, 1'b0);
      chk("mid_rst_count", int'(fifo_count), 0);
      chk("mid_rst_valid", int'(aer_valid), 0);
      chk("mid_rst_ready", int'(spike_ready), 1);
      cyc(1'b0, 1'b1, 8'h04, 1'b1);
      idle(1'b1);
      chk("mid_next_valid", int'(aer_valid), 1);
      chk("mid_next_addr", int'(aer_addr), 2);
      chk("mid_next_ts", int'(aer_ts), 0);

      // Randomized traffic against the model
      for (int k = 0; k < 3000; k++) begin
         cyc(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0,
             ($urandom_range(0, 9) < 3) ? 1'b1 : 1'b0,
             8'($urandom),
             ($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
